// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU operation codes and RV32 opcode/funct7 constants
//               used by the ALU issue stage and its decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU operation encodings consumed by the execute stage
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_LUI   = 4'd10;
  localparam logic [3:0] ALU_AUIPC = 4'd11;

  // Major opcodes handled by this stage
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  // funct7 qualifiers
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Base (funct7 = 0) mapping of funct3 to an ALU op, shared by OP and OP-IMM
  function automatic logic [3:0] base_op(input logic [2:0] funct3);
    logic [3:0] op;
    op = ALU_ADD;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_issue_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_decode
// Description : Combinational decode of an RV32 OP / OP-IMM / LUI / AUIPC
//               instruction into an ALU op and its two operands.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_decode
  import alu_pkg::*;
#(
  parameter int         XLEN       = 32,
  parameter logic [3:0] ILLEGAL_OP = 4'b0000
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [3:0]      op,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [4:0]      rd,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = XLEN'($signed(instr[31:20]));
  assign imm_u  = XLEN'({instr[31:12], 12'd0});
  assign rd     = instr[11:7];

  // Decode op and operands; any unrecognised encoding collapses to the illegal bundle
  always_comb begin
    logic ok;
    ok      = 1'b0;
    op      = ILLEGAL_OP;
    a       = '0;
    b       = '0;
    case (opcode)
      OPC_OP: begin
        a = rs1;
        b = rs2;
        if (funct7 == F7_BASE) begin
          ok = 1'b1;
          op = base_op(funct3);
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) begin
            ok = 1'b1;
            op = ALU_SUB;
          end else if (funct3 == 3'b101) begin
            ok = 1'b1;
            op = ALU_SRA;
          end
        end
      end
      OPC_OPIMM: begin
        a = rs1;
        b = imm_i;
        if (funct3 == 3'b001) begin
          ok = (funct7 == F7_BASE);
          op = ALU_SLL;
        end else if (funct3 == 3'b101) begin
          // Shift-right flavour is carried in the upper immediate bits
          if (funct7 == F7_BASE) begin
            ok = 1'b1;
            op = ALU_SRL;
          end else if (funct7 == F7_ALT) begin
            ok = 1'b1;
            op = ALU_SRA;
          end
        end else begin
          ok = 1'b1;
          op = base_op(funct3);
        end
      end
      OPC_LUI: begin
        ok = 1'b1;
        op = ALU_LUI;
        a  = '0;
        b  = imm_u;
      end
      OPC_AUIPC: begin
        ok = 1'b1;
        op = ALU_AUIPC;
        a  = pc;
        b  = imm_u;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      op = ILLEGAL_OP;
      a  = '0;
      b  = '0;
    end
    illegal = !ok;
  end

endmodule : alu_issue_decode
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue
// Description : ALU issue stage. Decodes the incoming instruction and holds
//               the result in a main register plus a one-entry skid register
//               behind a valid/ready handshake; in_ready is registered.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue
  import alu_pkg::*;
#(
  parameter logic [3:0] ILLEGAL_OP = 4'b0000,
  parameter int         XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_op,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  // Decoded view of the instruction currently on the input
  logic [3:0]      dec_op;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [4:0]      dec_rd;
  logic            dec_illegal;

  alu_issue_decode #(
    .XLEN       (XLEN),
    .ILLEGAL_OP (ILLEGAL_OP)
  ) u_decode (
    .instr   (in_instr),
    .pc      (in_pc),
    .rs1     (in_rs1_data),
    .rs2     (in_rs2_data),
    .op      (dec_op),
    .a       (dec_a),
    .b       (dec_b),
    .rd      (dec_rd),
    .illegal (dec_illegal)
  );

  // Main (output-facing) entry
  logic            main_valid_q, main_valid_d;
  logic [3:0]      main_op_q,    main_op_d;
  logic [XLEN-1:0] main_a_q,     main_a_d;
  logic [XLEN-1:0] main_b_q,     main_b_d;
  logic [4:0]      main_rd_q,    main_rd_d;
  logic            main_ill_q,   main_ill_d;

  // Skid entry, filled only when the main entry is stalled
  logic            skid_valid_q, skid_valid_d;
  logic [3:0]      skid_op_q,    skid_op_d;
  logic [XLEN-1:0] skid_a_q,     skid_a_d;
  logic [XLEN-1:0] skid_b_q,     skid_b_d;
  logic [4:0]      skid_rd_q,    skid_rd_d;
  logic            skid_ill_q,   skid_ill_d;

  logic            in_ready_q,   in_ready_d;

  logic acc;
  logic pop;

  assign acc = in_valid & in_ready_q;
  assign pop = main_valid_q & out_ready;

  // Next-state for the two-entry buffer; flush wins over any transfer
  always_comb begin
    main_valid_d = main_valid_q;
    main_op_d    = main_op_q;
    main_a_d     = main_a_q;
    main_b_d     = main_b_q;
    main_rd_d    = main_rd_q;
    main_ill_d   = main_ill_q;
    skid_valid_d = skid_valid_q;
    skid_op_d    = skid_op_q;
    skid_a_d     = skid_a_q;
    skid_b_d     = skid_b_q;
    skid_rd_d    = skid_rd_q;
    skid_ill_d   = skid_ill_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low here, so only the drain path matters
      if (pop) begin
        main_valid_d = 1'b1;
        main_op_d    = skid_op_q;
        main_a_d     = skid_a_q;
        main_b_d     = skid_b_q;
        main_rd_d    = skid_rd_q;
        main_ill_d   = skid_ill_q;
        skid_valid_d = 1'b0;
      end
    end else if (acc && (!main_valid_q || pop)) begin
      main_valid_d = 1'b1;
      main_op_d    = dec_op;
      main_a_d     = dec_a;
      main_b_d     = dec_b;
      main_rd_d    = dec_rd;
      main_ill_d   = dec_illegal;
    end else if (acc) begin
      skid_valid_d = 1'b1;
      skid_op_d    = dec_op;
      skid_a_d     = dec_a;
      skid_b_d     = dec_b;
      skid_rd_d    = dec_rd;
      skid_ill_d   = dec_illegal;
    end else if (pop) begin
      main_valid_d = 1'b0;
    end

    in_ready_d = !skid_valid_d;
  end

  // Buffer registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_op_q    <= '0;
      main_a_q     <= '0;
      main_b_q     <= '0;
      main_rd_q    <= '0;
      main_ill_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_op_q    <= '0;
      skid_a_q     <= '0;
      skid_b_q     <= '0;
      skid_rd_q    <= '0;
      skid_ill_q   <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_op_q    <= main_op_d;
      main_a_q     <= main_a_d;
      main_b_q     <= main_b_d;
      main_rd_q    <= main_rd_d;
      main_ill_q   <= main_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_op_q    <= skid_op_d;
      skid_a_q     <= skid_a_d;
      skid_b_q     <= skid_b_d;
      skid_rd_q    <= skid_rd_d;
      skid_ill_q   <= skid_ill_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign out_alu_op  = main_op_q;
  assign out_a       = main_a_q;
  assign out_b       = main_b_q;
  assign out_rd      = main_rd_q;
  assign out_illegal = main_ill_q;

endmodule : alu_issue
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue
// Description : Self-checking bench for alu_issue: directed decode cases,
//               backpressure, flush and reset, then randomized traffic
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_op;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [4:0]  out_rd;
  logic        out_illegal;

  alu_issue #(.ILLEGAL_OP(4'b0000), .XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_alu_op  (out_alu_op),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_popped = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference decode straight from the ISA rules
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    int   tbl[8] = '{0, 5, 8, 9, 4, 6, 3, 2};
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3  = ins[14:12];
    logic [6:0] f7  = ins[31:25];
    int   op = -1;
    logic [31:0] a = 0, b = 0;
    if (opc == 7'h33) begin
      a = r1; b = r2;
      if (f7 == 7'h00) op = tbl[f3];
      else if (f7 == 7'h20 && f3 == 0) op = 1;
      else if (f7 == 7'h20 && f3 == 5) op = 7;
    end else if (opc == 7'h13) begin
      a = r1;
      b = {{20{ins[31]}}, ins[31:20]};
      if (f3 == 1) op = (f7 == 0) ? 5 : -1;
      else if (f3 == 5) op = (f7 == 0) ? 6 : (f7 == 7'h20) ? 7 : -1;
      else op = tbl[f3];
    end else if (opc == 7'h37) begin
      op = 10; a = 0; b = {ins[31:12], 12'h000};
    end else if (opc == 7'h17) begin
      op = 11; a = pc; b = {ins[31:12], 12'h000};
    end
    e.rd = ins[11:7];
    if (op < 0) begin
      e.op = 4'd0; e.a = 0; e.b = 0; e.ill = 1'b1;
    end else begin
      e.op = 4'(op); e.a = a; e.b = b; e.ill = 1'b0;
    end
    return e;
  endfunction

  // One clock: check present state against the model, drive, clock, update model
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic ordy, input logic fl, input logic rs,
                       output logic accepted);
    logic acc_m, pop_m;
    in_valid    = v;
    in_instr    = ins;
    in_pc       = pc;
    in_rs1_data = r1;
    in_rs2_data = r2;
    out_ready   = ordy;
    flush       = fl;
    rst_n       = !rs;
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
    if (exp_q.size() > 0) begin
      chk("out_alu_op", 32'(out_alu_op), 32'(exp_q[0].op));
      chk("out_a", out_a, exp_q[0].a);
      chk("out_b", out_b, exp_q[0].b);
      chk("out_rd", 32'(out_rd), 32'(exp_q[0].rd));
      chk("out_illegal", 32'(out_illegal), 32'(exp_q[0].ill));
    end
    acc_m    = v && (exp_q.size() < 2);
    pop_m    = ordy && (exp_q.size() > 0);
    accepted = acc_m && !fl && !rs;
    if (out_valid && ordy && !fl && !rs) n_popped++;
    @(posedge clk);
    #1;
    if (rs || fl) begin
      exp_q.delete();
    end else begin
      if (pop_m) void'(exp_q.pop_front());
      if (acc_m) exp_q.push_back(ref_decode(ins, pc, r1, r2));
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic idle(input logic ordy);
    logic dummy;
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, ordy, 1'b0, 1'b0, dummy);
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_op", 32'(out_alu_op), 32'd0);
    chk("rst_a", out_a, 32'd0);
    chk("rst_b", out_b, 32'd0);
    chk("rst_rd", 32'(out_rd), 32'd0);
    chk("rst_illegal", 32'(out_illegal), 32'd0);
  endtask

  // Send one instruction into an empty stage and compare against hand-computed values
  task automatic directed(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic ill);
    logic acc;
    cycle(1'b1, ins, pc, r1, r2, 1'b1, 1'b0, 1'b0, acc);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_op"}, 32'(out_alu_op), 32'(op));
    chk({tag, "_a"}, out_a, a);
    chk({tag, "_b"}, out_b, b);
    chk({tag, "_rd"}, 32'(out_rd), 32'(rd));
    chk({tag, "_ill"}, 32'(out_illegal), 32'(ill));
    idle(1'b1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] f7;
    logic [6:0] opc;
    logic [31:0] w;
    case ($urandom_range(0, 2))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    case ($urandom_range(0, 5))
      0, 1:    opc = 7'h33;
      2:       opc = 7'h13;
      3:       opc = 7'h37;
      4:       opc = 7'h17;
      default: opc = 7'($urandom);
    endcase
    w = $urandom;
    return {f7, w[24:7], opc};
  endfunction

  logic [31:0] bp_instr[4];
  int          bp_idx;
  logic        acc;
  int          budget;

  initial begin
    in_valid = 0; in_instr = 0; in_pc = 0; in_rs1_data = 0; in_rs2_data = 0;
    out_ready = 0; flush = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    check_reset_outputs();

    directed("add",   32'h003100B3, 32'h0,   32'd5, 32'd7, 4'd0,  32'd5,   32'd7,        5'd1, 1'b0);
    directed("sub",   32'h403100B3, 32'h0,   32'd5, 32'd7, 4'd1,  32'd5,   32'd7,        5'd1, 1'b0);
    directed("addi",  32'hFFF00293, 32'h0,   32'd0, 32'd9, 4'd0,  32'd0,   32'hFFFFFFFF, 5'd5, 1'b0);
    directed("srai",  32'h4043D313, 32'h0,   32'h80, 32'd1, 4'd7, 32'h80,  32'h00000404, 5'd6, 1'b0);
    directed("lui",   32'h123450B7, 32'h40,  32'd3, 32'd4, 4'd10, 32'd0,   32'h12345000, 5'd1, 1'b0);
    directed("auipc", 32'h00001117, 32'h100, 32'd3, 32'd4, 4'd11, 32'h100, 32'h00001000, 5'd2, 1'b0);
    directed("ecall", 32'h00000073, 32'h0,   32'd3, 32'd4, 4'd0,  32'd0,   32'd0,        5'd0, 1'b1);
    directed("badf7", 32'h023100B3, 32'h0,   32'd3, 32'd4, 4'd0,  32'd0,   32'd0,        5'd1, 1'b1);

    // Backpressure: four instructions, out_ready low for three cycles
    bp_instr[0] = 32'h00100093; bp_instr[1] = 32'h00200113;
    bp_instr[2] = 32'h00300193; bp_instr[3] = 32'h00400213;
    bp_idx = 0;
    n_popped = 0;
    repeat (3) begin
      cycle(bp_idx < 4, bp_instr[bp_idx & 3], 32'h0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, acc);
      if (acc) bp_idx++;
    end
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_held_rd", 32'(out_rd), 32'd1);
    budget = 0;
    while ((bp_idx < 4 || out_valid) && budget < 20) begin
      cycle(bp_idx < 4, bp_instr[bp_idx & 3], 32'h0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, acc);
      if (acc) bp_idx++;
      budget++;
    end
    chk("bp_drained_in_budget", 32'(budget < 20), 32'd1);
    chk("bp_emitted", 32'(n_popped), 32'd4);

    // Flush with both entries full; the offer in the flush cycle is dropped
    cycle(1'b1, 32'h00500293, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h00600313, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0, acc);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 32'h00700393, 32'h0, 0, 0, 1'b1, 1'b1, 1'b0, acc);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    idle(1'b1);

    // Reset mid-stream
    cycle(1'b1, 32'h00800413, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h00900493, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h00A00513, 32'h0, 0, 0, 1'b0, 1'b0, 1'b1, acc);
    check_reset_outputs();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic rs_r, fl_r;
      rs_r = ($urandom_range(0, 199) == 0);
      fl_r = ($urandom_range(0, 39) == 0);
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
            $urandom_range(0, 3) != 0, fl_r, rs_r, acc);
      if (rs_r) check_reset_outputs();
    end
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_issue
`default_nettype wire
